// File: rtl/muldiv_pkg.sv
// muldiv_pkg: operation/state types and operation-decode helpers for muldiv_unit.
package muldiv_pkg;

  // Encoding matches funct3 of the RISC-V M extension.
  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic is_div(input op_t op);
    return op inside {DIV, DIVU, REM, REMU};
  endfunction

  function automatic logic is_rem(input op_t op);
    return op inside {REM, REMU};
  endfunction

  function automatic logic is_signed_a(input op_t op);
    return op inside {MUL, MULH, MULHSU, DIV, REM};
  endfunction

  function automatic logic is_signed_b(input op_t op);
    return op inside {MUL, MULH, DIV, REM};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration on the shared {acc} register.
//   multiply: shift-add, multiplier bits consumed from acc[0], partial product grows from the top.
//   divide:   restoring subtract, dividend bits shifted out of the low half, quotient bits shifted in.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] part_s;
  logic [WIDTH:0] diff_s;

  // One shift-add or restoring-subtract step selected by operation class.
  always_comb begin
    sum_s  = '0;
    part_s = '0;
    diff_s = '0;
    acc_o  = acc_i;
    if (is_div_i) begin
      // Partial remainder stays below the divisor, so WIDTH+1 bits hold the shifted value.
      part_s = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
      diff_s = part_s - {1'b0, opnd_i};
      if (!diff_s[WIDTH]) begin
        acc_o = {diff_s[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = {part_s[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      sum_s = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
      acc_o = {sum_s, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide with valid/ready request and
// response handshakes, tagged results and a flush that aborts the operation in flight.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int STEPS     = 1,
  parameter int TAG_WIDTH = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  op_t                  req_op,
  input  logic [WIDTH-1:0]     req_a,
  input  logic [WIDTH-1:0]     req_b,
  input  logic [TAG_WIDTH-1:0] req_tag,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [WIDTH-1:0]     resp_result,
  output logic [TAG_WIDTH-1:0] resp_tag
);

  localparam int N  = WIDTH / STEPS;
  localparam int CW = $clog2(N + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t               state_q, state_d;
  op_t                  op_q, op_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic                 neg_q, neg_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0]     result_q, result_d;

  logic                 accept_s;
  logic                 neg_a_s, neg_b_s;
  logic [WIDTH-1:0]     mag_a_s, mag_b_s;
  logic                 div_zero_s, div_ovf_s, special_s;
  logic [WIDTH-1:0]     special_res_s;
  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH-1:0]     hi_s, lo_s;
  logic                 is_div_q_s;
  logic [2*WIDTH-1:0]   chain_s [STEPS+1];

  assign req_ready = (state_q == IDLE) && !flush && reset;
  assign accept_s  = req_valid && req_ready;

  // Operands are iterated as magnitudes; the result sign is re-applied in FIX.
  assign neg_a_s = is_signed_a(req_op) && req_a[WIDTH-1];
  assign neg_b_s = is_signed_b(req_op) && req_b[WIDTH-1];
  assign mag_a_s = neg_a_s ? -req_a : req_a;
  assign mag_b_s = neg_b_s ? -req_b : req_b;

  // Divide-by-zero and signed overflow never enter the iteration.
  assign div_zero_s    = is_div(req_op) && (req_b == '0);
  assign div_ovf_s     = is_div(req_op) && is_signed_a(req_op) && (req_a == MIN_VAL) && (req_b == '1);
  assign special_s     = div_zero_s || div_ovf_s;
  assign special_res_s = div_zero_s ? (is_rem(req_op) ? req_a : '1)
                                    : (is_rem(req_op) ? '0 : MIN_VAL);

  assign is_div_q_s = is_div(op_q);
  assign chain_s[0] = acc_q;

  for (genvar g = 0; g < STEPS; g++) begin : g_step
    muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div_i (is_div_q_s),
      .acc_i    (chain_s[g]),
      .opnd_i   (opnd_q),
      .acc_o    (chain_s[g+1])
    );
  end

  // Next-state and datapath update for IDLE -> BUSY -> FIX -> DONE, flush overrides all.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    tag_d        = tag_q;
    acc_d        = acc_q;
    opnd_d       = opnd_q;
    neg_d        = neg_q;
    count_d      = count_q;
    resp_valid_d = resp_valid_q;
    result_d     = result_q;
    // Products are negated across the full double width; quotient/remainder per half.
    prod_s = neg_q ? -acc_q : acc_q;
    hi_s   = neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    lo_s   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          op_d    = req_op;
          tag_d   = req_tag;
          acc_d   = {{WIDTH{1'b0}}, mag_a_s};
          opnd_d  = mag_b_s;
          neg_d   = is_rem(req_op) ? neg_a_s : (neg_a_s ^ neg_b_s);
          count_d = CW'(N);
          if (special_s) begin
            result_d     = special_res_s;
            resp_valid_d = 1'b1;
            state_d      = DONE;
          end else begin
            state_d = BUSY;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        acc_d   = chain_s[STEPS];
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d = FIX;
        end else begin
          state_d = BUSY;
        end
      end
      FIX: begin
        if (is_div_q_s) begin
          result_d = is_rem(op_q) ? hi_s : lo_s;
        end else begin
          result_d = (op_q == MUL) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
        end
        resp_valid_d = 1'b1;
        state_d      = DONE;
      end
      DONE: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        resp_valid_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
    if (flush) begin
      resp_valid_d = 1'b0;
      state_d      = IDLE;
    end else begin
      resp_valid_d = resp_valid_d;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      op_q         <= MUL;
      tag_q        <= '0;
      acc_q        <= '0;
      opnd_q       <= '0;
      neg_q        <= 1'b0;
      count_q      <= '0;
      resp_valid_q <= 1'b0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      tag_q        <= tag_d;
      acc_q        <= acc_d;
      opnd_q       <= opnd_d;
      neg_q        <= neg_d;
      count_q      <= count_d;
      resp_valid_q <= resp_valid_d;
      result_q     <= result_d;
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_result = result_q;
  assign resp_tag    = tag_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit at STEPS=1 (unit 0)
// and STEPS=4 (unit 1) against a plain-arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         flush       [2];
  logic         req_valid   [2];
  logic         req_ready   [2];
  op_t          req_op      [2];
  logic [W-1:0] req_a       [2];
  logic [W-1:0] req_b       [2];
  logic [4:0]   req_tag     [2];
  logic         resp_valid  [2];
  logic         resp_ready  [2];
  logic [W-1:0] resp_result [2];
  logic [4:0]   resp_tag    [2];

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(W), .STEPS(1), .TAG_WIDTH(5)) dut1 (
    .clock(clk), .reset(rst_n), .flush(flush[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_op(req_op[0]),
    .req_a(req_a[0]), .req_b(req_b[0]), .req_tag(req_tag[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_result(resp_result[0]), .resp_tag(resp_tag[0])
  );

  muldiv_unit #(.WIDTH(W), .STEPS(4), .TAG_WIDTH(5)) dut4 (
    .clock(clk), .reset(rst_n), .flush(flush[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_op(req_op[1]),
    .req_a(req_a[1]), .req_b(req_b[1]), .req_tag(req_tag[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_result(resp_result[1]), .resp_tag(resp_tag[1])
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Reference results from 64-bit integer arithmetic.
  function automatic logic [W-1:0] ref_res(input op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = longint'(a);
    ub = longint'(b);
    case (op)
      MUL:     begin p = sa * sb; return p[31:0]; end
      MULH:    begin p = sa * sb; return p[63:32]; end
      MULHSU:  begin p = sa * ub; return p[63:32]; end
      MULHU:   begin p = ua * ub; return p[63:32]; end
      DIV:     begin if (b == 32'd0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
      DIVU:    begin if (b == 32'd0) return 32'hFFFFFFFF; p = ua / ub; return p[31:0]; end
      REM:     begin if (b == 32'd0) return a; p = sa % sb; return p[31:0]; end
      REMU:    begin if (b == 32'd0) return a; p = ua % ub; return p[31:0]; end
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input int u, input op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
    if ((op inside {DIV, DIVU, REM, REMU}) && b == 32'd0) return 1;
    if ((op inside {DIV, REM}) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return (u == 0) ? 34 : 10;
  endfunction

  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom());
    endcase
  endfunction

  // Present one request in the current idle cycle; returns just after the accepting edge.
  task automatic start(input int u, input op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] tag);
    @(negedge clk);
    check("req_ready_idle", 64'(req_ready[u]), 64'd1);
    req_valid[u] = 1'b1;
    req_op[u]    = op;
    req_a[u]     = a;
    req_b[u]     = b;
    req_tag[u]   = tag;
    @(posedge clk);
    #1;
    req_valid[u] = 1'b0;
  endtask

  // Wait for the response, hold it under backpressure, then consume it.
  task automatic run(input int u, input op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [4:0] tag, input int hold, input logic [W-1:0] exp_res, input int exp_lat);
    int lat;
    logic [W-1:0] res;
    logic [4:0] rtag;
    start(u, op, a, b, tag);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (resp_valid[u] === 1'b1) begin
        lat = c;
        break;
      end
    end
    res  = resp_result[u];
    rtag = resp_tag[u];
    check("latency", 64'(lat), 64'(exp_lat));
    check("result", 64'(res), 64'(exp_res));
    check("tag", 64'(rtag), 64'(tag));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 64'(resp_valid[u]), 64'd1);
      check("hold_result", 64'(resp_result[u]), 64'(res));
      check("hold_tag", 64'(resp_tag[u]), 64'(rtag));
      check("hold_not_ready", 64'(req_ready[u]), 64'd0);
    end
    resp_ready[u] = 1'b1;
    @(posedge clk);
    #1;
    resp_ready[u] = 1'b0;
  endtask

  initial begin
    int saw;
    op_t op;
    logic [W-1:0] a, b;
    logic [4:0] tag;

    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      flush[u] = 1'b0; req_valid[u] = 1'b0; resp_ready[u] = 1'b0;
      req_op[u] = MUL; req_a[u] = '0; req_b[u] = '0; req_tag[u] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check("rst_resp_valid", 64'(resp_valid[u]), 64'd0);
      check("rst_resp_result", 64'(resp_result[u]), 64'd0);
      check("rst_resp_tag", 64'(resp_tag[u]), 64'd0);
      check("rst_req_ready", 64'(req_ready[u]), 64'd0);
    end
    rst_n = 1'b1;

    // Multiply family
    run(0, MUL,    32'd7,        32'hFFFFFFFD, 5'h15, 0, 32'hFFFFFFEB, 34);
    run(0, MULH,   32'h80000000, 32'h80000000, 5'h01, 0, 32'h40000000, 34);
    run(0, MULHU,  32'h80000000, 32'h80000000, 5'h02, 0, 32'h40000000, 34);
    run(0, MULHSU, 32'hFFFFFFFF, 32'd2,        5'h03, 0, 32'hFFFFFFFF, 34);
    // Divide special cases resolve immediately
    run(0, DIV,    32'd5,        32'd0,        5'h04, 0, 32'hFFFFFFFF, 1);
    run(0, REM,    32'd5,        32'd0,        5'h05, 0, 32'd5,        1);
    run(0, DIV,    32'h80000000, 32'hFFFFFFFF, 5'h06, 0, 32'h80000000, 1);
    run(0, REM,    32'h80000000, 32'hFFFFFFFF, 5'h07, 0, 32'd0,        1);
    // Iterated divides, one under backpressure
    run(0, DIVU,   32'd100,      32'd7,        5'h08, 5, 32'd14,       34);
    run(0, REMU,   32'd100,      32'd7,        5'h09, 0, 32'd2,        34);
    run(0, REM,    32'hFFFFFFF9, 32'd2,        5'h0A, 0, 32'hFFFFFFFF, 34);
    run(0, DIV,    32'hFFFFFF9C, 32'd7,        5'h0B, 2, 32'hFFFFFFF2, 34);

    // Flush in C10 of a divide, with a competing request in the same cycle
    start(0, DIV, 32'd1000, 32'd3, 5'h0C);
    repeat (10) @(negedge clk);
    check("busy_not_ready", 64'(req_ready[0]), 64'd0);
    flush[0] = 1'b1;
    req_valid[0] = 1'b1; req_op[0] = MUL; req_a[0] = 32'd3; req_b[0] = 32'd4; req_tag[0] = 5'h1F;
    check("flush_blocks_ready", 64'(req_ready[0]), 64'd0);
    @(posedge clk);
    #1;
    flush[0] = 1'b0;
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("ready_after_flush", 64'(req_ready[0]), 64'd1);
    check("valid_after_flush", 64'(resp_valid[0]), 64'd0);
    saw = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (resp_valid[0] !== 1'b0) saw = 1;
    end
    check("no_resp_after_flush", 64'(saw), 64'd0);

    // Randomized operations with random backpressure on both units
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < ((u == 0) ? 150 : 1500); i++) begin
        op  = op_t'($urandom_range(0, 7));
        a   = rnd_opnd();
        b   = rnd_opnd();
        tag = 5'($urandom_range(0, 31));
        run(u, op, a, b, tag, $urandom_range(0, 3), ref_res(op, a, b), ref_lat(u, op, a, b));
      end
    end

    // Reset in the middle of a multiply clears outputs and returns to idle
    start(1, MULHU, 32'hDEADBEEF, 32'h12345678, 5'h11);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_valid", 64'(resp_valid[1]), 64'd0);
    check("midrst_result", 64'(resp_result[1]), 64'd0);
    check("midrst_tag", 64'(resp_tag[1]), 64'd0);
    run(1, MUL, 32'd6, 32'd7, 5'h12, 0, 32'd42, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
